dac_out_gate: RTL and testbench
===============================

Name: dac_out_gate

Overview:
- Sits directly downstream of the gain multiplier stage. Consumes its signed 16-bit product and its per-sample overflow flag.
- Drives the DAC word through a trigger-started, programmable delay/width output window.
- Adds a signed DAC offset with saturation.
- Counts multiplier overflows within the window. Optionally trips (forces zero output) once a programmable overflow count is reached.

Parameters:
- DLY_W, 8, width of delay field/counter
- WIN_W, 10, width of window-width field/counter
- CNT_W, 4, width of overflow counter and limit

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- trig  input  1  window start request, single-cycle pulse or level
- delay  input  DLY_W  cycles from trigger acceptance to first active cycle, unsigned
- width  input  WIN_W  number of active cycles, unsigned
- din  input  16  signed sample from gain multiplier
- oflowIn  input  1  overflow flag from gain multiplier, aligned with din
- dacOffset  input  16  signed offset added to din
- tripEn  input  1  enables overflow trip
- oflowLimit  input  CNT_W  overflow count that trips the output; 0 = never trip
- dout  output  16  signed DAC word, registered
- gateActive  output  1  high when dout carries window data, aligned with dout
- busy  output  1  high in DELAY or ACTIVE
- tripped  output  1  sticky trip flag
- oflowCount  output  CNT_W  overflows seen in current/last window, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, dout=0, gateActive=0, busy=0, tripped=0, oflowCount=0, all counters 0. Reset mid-window aborts immediately; the first trigger after reset release starts a fresh window.
- States:
  - IDLE: trig=1 at cycle T latches delay and width, clears tripped and oflowCount. Next state is DELAY, or ACTIVE if delay=0. If width=0 the trigger is accepted and counters clear, but the state stays IDLE: no output, busy never asserts.
  - DELAY: decrements the delay counter; moves to ACTIVE after exactly `delay` cycles in DELAY.
  - ACTIVE: lasts exactly `width` cycles, then returns to IDLE.
- Timing: the first ACTIVE cycle is T+1+delay. busy = (state != IDLE), combinational from state register.
- Trigger handling: trig is ignored outside IDLE; no queuing, no retrigger. A level-high trig re-arms on the first IDLE cycle after the window ends, i.e. back-to-back windows with a one-cycle IDLE gap.
- Data path, one cycle latency:
  - At each clock, if state=ACTIVE and tripped=0 (pre-update value): dout <= sat16(din + dacOffset) and gateActive <= 1.
  - Otherwise dout <= 0 and gateActive <= 0.
  - Addition is done at 17 bits. Results above 32767 clamp to 32767; below -32768 clamp to -32768.
- Overflow counting:
  - Only in ACTIVE cycles with oflowIn=1: oflowCount increments, saturating at 2^CNT_W-1.
  - Trip condition: tripEn=1, oflowLimit!=0, and the post-increment count >= oflowLimit. Then tripped <= 1 on that edge.
  - The sample carrying the tripping overflow is still output. Zeroing starts the following cycle.
  - tripped and oflowCount hold after the window ends, until the next accepted trigger or reset.
- Control inputs tripEn and oflowLimit are read live; delay, width and dacOffset changes take effect as follows: delay/width only at trigger acceptance, dacOffset is used live.

Test Plan:
- Reset, then trig pulse at T with delay=3, width=5, din ramp 1..N, offset 0 -> busy from T+1. gateActive high at T+5..T+9 (dout edges after ACTIVE cycles T+4..T+8). dout equals din from T+4..T+8. Zero otherwise.
- delay=0, width=1; trig at T -> exactly one active output at T+2 = din(T+1). delay=2, width=0 -> busy never asserts, dout stays 0.
- Saturation: din=32000, dacOffset=1000 -> 32767. din=-32000, offset=-1000 -> -32768. din=-5, offset=3 -> -2.
- Trip: tripEn=1, oflowLimit=2, width=10, oflowIn high on active cycles 3 and 6 -> oflowCount=2, tripped rises after cycle 6. Cycle 6 sample is output; cycles 7..10 give dout=0, gateActive=0. Next trig clears tripped and count. Repeat with oflowLimit=0 -> no trip, count=2.
- trig held high through a window with width=4 and retriggered during DELAY/ACTIVE -> no restart. A new window starts on the first IDLE cycle. Assert rst mid-ACTIVE -> dout=0 and gateActive=0 immediately (async), state IDLE after release.

Source files
------------

// File: rtl/dac_out_gate.sv
// dac_out_gate: trigger-started, delay/width gated DAC output stage.
// Adds a signed offset with 16-bit saturation to the gain-multiplier product,
// emits it only inside the programmed window, and counts multiplier overflows
// seen inside the window with an optional trip that zeroes the output.
module dac_out_gate #(
    parameter int DLY_W = 8,
    parameter int WIN_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [DLY_W-1:0] delay,
    input  logic [WIN_W-1:0] width,
    input  logic [15:0]      din,
    input  logic             oflowIn,
    input  logic [15:0]      dacOffset,
    input  logic             tripEn,
    input  logic [CNT_W-1:0] oflowLimit,
    output logic [15:0]      dout,
    output logic             gateActive,
    output logic             busy,
    output logic             tripped,
    output logic [CNT_W-1:0] oflowCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic [DLY_W-1:0] dly_cnt_r;
    logic [DLY_W-1:0] dly_cnt_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_cnt_s;
    logic [15:0]      dout_s;
    logic             gate_s;
    logic             tripped_s;
    logic [CNT_W-1:0] oflow_cnt_s;
    logic [CNT_W-1:0] oflow_inc_s;

    // Signed 16-bit add evaluated at 17 bits, clamped to the 16-bit range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
            sat_add16 = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat_add16 = sum[15:0];
        end
    endfunction

    // Overflow count incremented by one, holding at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX) begin
            sat_inc = c;
        end else begin
            sat_inc = c + CNT_ONE;
        end
    endfunction

    assign busy = (state_r != ST_IDLE);

    // Window sequencing, data path select and overflow/trip bookkeeping.
    always_comb begin
        state_s     = state_r;
        dly_cnt_s   = dly_cnt_r;
        win_cnt_s   = win_cnt_r;
        dout_s      = 16'h0000;
        gate_s      = 1'b0;
        tripped_s   = tripped;
        oflow_cnt_s = oflowCount;
        oflow_inc_s = sat_inc(oflowCount);
        case (state_r)
            ST_IDLE: begin
                if (trig) begin
                    // A zero-width trigger still clears the trip status.
                    tripped_s   = 1'b0;
                    oflow_cnt_s = CNT_ZERO;
                    win_cnt_s   = width;
                    dly_cnt_s   = delay;
                    if (width == WIN_ZERO) begin
                        state_s = ST_IDLE;
                    end else if (delay == DLY_ZERO) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        state_s = ST_DELAY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (dly_cnt_r <= DLY_ONE) begin
                    state_s   = ST_ACTIVE;
                    dly_cnt_s = DLY_ZERO;
                end else begin
                    dly_cnt_s = dly_cnt_r - DLY_ONE;
                end
            end
            ST_ACTIVE: begin
                // Trip state before this edge decides output, so the tripping sample is still sent.
                if (!tripped) begin
                    dout_s = sat_add16(din, dacOffset);
                    gate_s = 1'b1;
                end else begin
                    dout_s = 16'h0000;
                    gate_s = 1'b0;
                end
                if (oflowIn) begin
                    oflow_cnt_s = oflow_inc_s;
                    if (tripEn && (oflowLimit != CNT_ZERO) && (oflow_inc_s >= oflowLimit)) begin
                        tripped_s = 1'b1;
                    end else begin
                        tripped_s = tripped;
                    end
                end else begin
                    oflow_cnt_s = oflowCount;
                end
                if (win_cnt_r <= WIN_ONE) begin
                    state_s   = ST_IDLE;
                    win_cnt_s = WIN_ZERO;
                end else begin
                    win_cnt_s = win_cnt_r - WIN_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                dly_cnt_s = DLY_ZERO;
                win_cnt_s = WIN_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dly_cnt_r  <= DLY_ZERO;
            win_cnt_r  <= WIN_ZERO;
            dout       <= 16'h0000;
            gateActive <= 1'b0;
            tripped    <= 1'b0;
            oflowCount <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            dly_cnt_r  <= dly_cnt_s;
            win_cnt_r  <= win_cnt_s;
            dout       <= dout_s;
            gateActive <= gate_s;
            tripped    <= tripped_s;
            oflowCount <= oflow_cnt_s;
        end
    end

endmodule

// File: tb/tb_dac_out_gate.sv
// Self-checking bench for dac_out_gate: window-level reference model,
// saturation vector table, directed corner sequences and random stimulus.
module tb_dac_out_gate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [7:0]  delay = 8'd0;
    logic [9:0]  width = 10'd0;
    logic [15:0] din = 16'd0;
    logic        oflowIn = 1'b0;
    logic [15:0] dacOffset = 16'd0;
    logic        tripEn = 1'b0;
    logic [3:0]  oflowLimit = 4'd0;
    logic [15:0] dout;
    logic        gateActive;
    logic        busy;
    logic        tripped;
    logic [3:0]  oflowCount;

    dac_out_gate #(.DLY_W(8), .WIN_W(10), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .trig(trig), .delay(delay), .width(width),
        .din(din), .oflowIn(oflowIn), .dacOffset(dacOffset), .tripEn(tripEn),
        .oflowLimit(oflowLimit), .dout(dout), .gateActive(gateActive),
        .busy(busy), .tripped(tripped), .oflowCount(oflowCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a window is described by its acceptance edge and the
    // range of edges that are active, all as absolute edge numbers.
    longint cyc = 0;
    bit     m_valid = 1'b0;
    longint m_tacc = 0;
    longint m_astart = 0;
    longint m_aend = 0;
    bit     m_trip = 1'b0;
    int     m_cnt = 0;
    logic [15:0] m_dout = 16'd0;
    bit     m_gate = 1'b0;
    int     gate_seen = 0;
    int     busy_seen = 0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] off;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_sat(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic bit in_busy(input longint n);
        return m_valid && (n >= m_tacc + 1) && (n <= m_aend);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_trip  = 1'b0;
        m_cnt   = 0;
        m_dout  = 16'd0;
        m_gate  = 1'b0;
    endtask

    // Applies the rules for one clock edge using the inputs present at it.
    task automatic model_edge();
        bit act;
        bit idle;
        act  = m_valid && (cyc >= m_astart) && (cyc <= m_aend);
        idle = !in_busy(cyc);
        if (act && !m_trip) begin
            m_dout = ref_sat(din, dacOffset);
            m_gate = 1'b1;
        end else begin
            m_dout = 16'd0;
            m_gate = 1'b0;
        end
        if (act && oflowIn) begin
            if (m_cnt < 15) m_cnt++;
            if (tripEn && oflowLimit != 4'd0 && m_cnt >= int'(oflowLimit)) m_trip = 1'b1;
        end
        if (idle && trig) begin
            m_trip = 1'b0;
            m_cnt  = 0;
            if (width != 10'd0) begin
                m_valid  = 1'b1;
                m_tacc   = cyc;
                m_astart = cyc + 1 + longint'(delay);
                m_aend   = cyc + longint'(delay) + longint'(width);
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("gateActive", 32'(gateActive), 32'(m_gate));
        chk("busy", 32'(busy), 32'(in_busy(cyc)));
        chk("tripped", 32'(tripped), 32'(m_trip));
        chk("oflowCount", 32'(oflowCount), 32'(m_cnt));
        if (gateActive) gate_seen++;
        if (busy) busy_seen++;
    endtask

    task automatic start(input logic [7:0] d, input logic [9:0] w);
        delay = d;
        width = w;
        trig  = 1'b1;
        step();
        trig  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'sd32000,  16'sd1000,  16'sd32767};
        vecs[1] = '{-16'sd32000, -16'sd1000, -16'sd32768};
        vecs[2] = '{-16'sd5,     16'sd3,     -16'sd2};
        vecs[3] = '{16'sd100,    -16'sd100,  16'sd0};
        vecs[4] = '{16'sd32767,  16'sd0,     16'sd32767};
        vecs[5] = '{-16'sd32768, -16'sd1,    -16'sd32768};
        vecs[6] = '{16'sd1,      16'sd2,     16'sd3};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_gate", 32'(gateActive), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tripped", 32'(tripped), 32'd0);
        chk("rst_count", 32'(oflowCount), 32'd0);

        // Ramp through a delay=3 width=5 window
        gate_seen = 0;
        din = 16'd1;
        delay = 8'd3; width = 10'd5; trig = 1'b1;
        step();
        trig = 1'b0;
        chk("ramp_busy_T1", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            din = din + 16'd1;
            step();
        end
        chk("ramp_gate_count", 32'(gate_seen), 32'd5);

        // delay=0 width=1: single output
        gate_seen = 0;
        din = 16'd77;
        start(8'd0, 10'd1);
        din = 16'd78;
        step();
        chk("single_dout", 32'(dout), 32'd78);
        for (int i = 0; i < 3; i++) step();
        chk("single_gate_count", 32'(gate_seen), 32'd1);

        // width=0: accepted but never busy
        busy_seen = 0; gate_seen = 0;
        start(8'd2, 10'd0);
        for (int i = 0; i < 5; i++) step();
        chk("w0_busy_seen", 32'(busy_seen), 32'd0);
        chk("w0_gate_seen", 32'(gate_seen), 32'd0);

        // Saturation table inside one long window
        start(8'd0, 10'd8);
        for (int i = 0; i < 7; i++) begin
            din = vecs[i].din;
            dacOffset = vecs[i].off;
            step();
            chk($sformatf("sat_vec%0d", i), 32'(dout), 32'(vecs[i].exp));
        end
        dacOffset = 16'd0;
        for (int i = 0; i < 3; i++) step();

        // Trip at second overflow, then same window without trip
        for (int pass = 0; pass < 2; pass++) begin
            tripEn = 1'b1;
            oflowLimit = (pass == 0) ? 4'd2 : 4'd0;
            gate_seen = 0;
            din = 16'd500;
            start(8'd1, 10'd10);
            step();
            for (int a = 1; a <= 10; a++) begin
                oflowIn = (a == 3 || a == 6);
                din = 16'(1000 + a);
                step();
                if (pass == 0 && a == 6) chk("trip_last_sample", 32'(dout), 32'd1006);
            end
            oflowIn = 1'b0;
            step();
            chk("trip_count", 32'(oflowCount), 32'd2);
            chk("trip_flag", 32'(tripped), (pass == 0) ? 32'd1 : 32'd0);
            chk("trip_gate_count", 32'(gate_seen), (pass == 0) ? 32'd6 : 32'd10);
        end
        start(8'd0, 10'd0);
        chk("retrig_clears_trip", 32'(tripped), 32'd0);
        chk("retrig_clears_count", 32'(oflowCount), 32'd0);
        tripEn = 1'b0;

        // Level trigger: windows every 7 edges, no restart while busy
        gate_seen = 0;
        delay = 8'd2; width = 10'd4; trig = 1'b1;
        for (int i = 0; i < 21; i++) step();
        trig = 1'b0;
        chk("level_gate_count", 32'(gate_seen), 32'd12);
        for (int i = 0; i < 8; i++) step();

        // Async reset mid-window
        din = 16'd1234;
        start(8'd0, 10'd10);
        step();
        step();
        chk("pre_rst_gate", 32'(gateActive), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_dout", 32'(dout), 32'd0);
        chk("async_rst_gate", 32'(gateActive), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            trig       = ($urandom_range(0, 7) == 0);
            delay      = 8'($urandom_range(0, 5));
            width      = 10'($urandom_range(0, 12));
            din        = 16'($urandom);
            dacOffset  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
            oflowIn    = ($urandom_range(0, 3) == 0);
            tripEn     = 1'($urandom_range(0, 1));
            oflowLimit = 4'($urandom_range(0, 4));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
